// File: rtl/commit_rob.sv
// commit_rob: in-order commit buffer between the execute/writeback path and the ARF.
// Decode allocates entries in program order, results return out of order by tag,
// and completed entries retire strictly in order, one per cycle, onto the ARF write port.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   alloc_valid/rd/regwrite  allocation request from decode
//   alloc_ready, alloc_tag   slot available (registered count < DEPTH), tag = tail pointer
//   wb_valid/tag/data        out-of-order result return
//   flush                    discard every entry (mispredict)
//   commit_valid/regwrite/rd/data  registered ARF write port
//   count                    occupied entries
//
// Optional feature macro: COMMIT_BYPASS_EN -- a writeback to the not-yet-done head
// entry commits on the same edge using wb_data (t+1 instead of t+2).
module commit_rob #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned TAG_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alloc_valid,
    input  logic [4:0]       alloc_rd,
    input  logic             alloc_regwrite,
    output logic             alloc_ready,
    output logic [TAG_W-1:0] alloc_tag,
    input  logic             wb_valid,
    input  logic [TAG_W-1:0] wb_tag,
    input  logic [31:0]      wb_data,
    input  logic             flush,
    output logic             commit_valid,
    output logic             commit_regwrite,
    output logic [4:0]       commit_rd,
    output logic [31:0]      commit_data,
    output logic [TAG_W:0]   count
);

    localparam int unsigned CNT_W  = TAG_W + 1;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned RD_W   = 5;

    logic [DEPTH-1:0]  ent_valid;
    logic [DEPTH-1:0]  ent_done;
    logic [DEPTH-1:0]  ent_regwrite;
    logic [RD_W-1:0]   ent_rd   [DEPTH];
    logic [DATA_W-1:0] ent_data [DEPTH];

    logic [TAG_W-1:0]  head;
    logic [TAG_W-1:0]  tail;

    logic              alloc_fire;
    logic              wb_hit;
    logic              commit_fire;
    logic [DATA_W-1:0] head_data;

    // Ready looks only at registered count; a same-cycle commit never frees a slot.
    assign alloc_ready = (count < CNT_W'(DEPTH));
    assign alloc_tag   = tail;
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign wb_hit      = wb_valid && ent_valid[wb_tag];

    // Head retirement decision and the data it carries.
    always_comb begin
        commit_fire = ent_valid[head] && ent_done[head];
        head_data   = ent_data[head];
`ifdef COMMIT_BYPASS_EN
        if (wb_valid && (wb_tag == head) && ent_valid[head] && !ent_done[head]) begin
            commit_fire = 1'b1;
            head_data   = wb_data;
        end
`endif
    end

    // Control state: pointers, count, valid/done bits and the commit port.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            head            <= '0;
            tail            <= '0;
            count           <= '0;
            ent_valid       <= '0;
            ent_done        <= '0;
            commit_valid    <= 1'b0;
            commit_regwrite <= 1'b0;
            commit_rd       <= '0;
            commit_data     <= '0;
        end else begin
            if (wb_hit) begin
                ent_done[wb_tag] <= 1'b1;
            end
            // Alloc targets an invalid slot, so it never collides with wb or commit.
            if (alloc_fire) begin
                ent_valid[tail] <= 1'b1;
                ent_done[tail]  <= 1'b0;
                tail            <= tail + TAG_W'(1);
            end
            if (commit_fire) begin
                ent_valid[head] <= 1'b0;
                ent_done[head]  <= 1'b0;
                head            <= head + TAG_W'(1);
            end
            count           <= count + CNT_W'(alloc_fire) - CNT_W'(commit_fire);
            commit_valid    <= commit_fire;
            commit_regwrite <= commit_fire && ent_regwrite[head] && (ent_rd[head] != '0);
            commit_rd       <= commit_fire ? ent_rd[head] : '0;
            commit_data     <= commit_fire ? head_data : '0;
        end
    end

    // Payload storage; contents are meaningless unless the valid bit is set.
    always_ff @(posedge clk) begin
        if (!reset && !flush) begin
            if (wb_hit) begin
                ent_data[wb_tag] <= wb_data;
            end
            if (alloc_fire) begin
                ent_rd[tail]       <= alloc_rd;
                ent_regwrite[tail] <= alloc_regwrite;
            end
        end
    end

endmodule
